// File: rtl/cntr_arb.sv
// Shared up-counter arbitrated round-robin between two requesters.
// Each granted run counts 0..limit, pulses done, then returns the counter to IDLE.
module cntr_arb #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             pulse,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] lim0,
    input  logic [WIDTH-1:0] lim1,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] o,
    output logic [1:0]       done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_ptr;
    logic             w_ptr_nx;
    logic             r_own;
    logic             w_own_nx;
    logic [1:0]       r_gnt;
    logic [1:0]       w_gnt_nx;
    logic [1:0]       r_done;
    logic [1:0]       w_done_nx;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nx;
    logic [WIDTH-1:0] r_lim;
    logic [WIDTH-1:0] w_lim_nx;
    logic             w_pick;
    logic             w_own_req;
    logic             w_at_lim;

    // Contention resolves by the pointer; a lone requester always wins.
    always_comb begin
        if (req == 2'b11) begin
            w_pick = r_ptr;
        end else begin
            w_pick = req[1] & ~req[0];
        end
    end

    assign w_own_req = req[r_own];
    assign w_at_lim  = (r_cnt == r_lim);

    always_ff @(posedge pulse or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
            r_own   <= 1'b0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_cnt   <= '0;
            r_lim   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_own   <= w_own_nx;
            r_gnt   <= w_gnt_nx;
            r_done  <= w_done_nx;
            r_cnt   <= w_cnt_nx;
            r_lim   <= w_lim_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_own_nx   = r_own;
        w_gnt_nx   = r_gnt;
        w_done_nx  = '0;
        w_cnt_nx   = r_cnt;
        w_lim_nx   = r_lim;

        case (r_state)
            IDLE: begin
                w_gnt_nx = '0;
                if (req != 2'b00) begin
                    w_own_nx   = w_pick;
                    w_gnt_nx   = w_pick ? 2'b10 : 2'b01;
                    w_cnt_nx   = '0;
                    w_lim_nx   = w_pick ? lim1 : lim0;
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                // Losing the owner's request beats reaching the limit.
                if (!w_own_req) begin
                    w_gnt_nx   = '0;
                    w_ptr_nx   = ~r_own;
                    w_state_nx = IDLE;
                end else if (w_at_lim) begin
                    w_gnt_nx   = '0;
                    w_done_nx  = r_own ? 2'b10 : 2'b01;
                    w_state_nx = DONE;
                end else begin
                    w_cnt_nx = r_cnt + ONE;
                end
            end
            DONE: begin
                w_gnt_nx   = '0;
                w_ptr_nx   = ~r_own;
                w_state_nx = IDLE;
            end
            default: begin
                w_gnt_nx   = '0;
                w_state_nx = IDLE;
            end
        endcase
    end

    assign gnt  = r_gnt;
    assign o    = r_cnt;
    assign done = r_done;
    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_cntr_arb.sv
// Scoreboard bench for cntr_arb: a cycle model pushes expected outputs per edge,
// popped and compared one time unit after the edge, plus directed spot checks.
module tb_cntr_arb;

    localparam int W = 4;

    logic         pulse = 1'b0;
    logic         reset;
    logic [1:0]   req;
    logic [W-1:0] lim0;
    logic [W-1:0] lim1;
    logic [1:0]   gnt;
    logic [W-1:0] o;
    logic [1:0]   done;
    logic         busy;

    cntr_arb #(.WIDTH(W)) dut (
        .pulse (pulse),
        .reset (reset),
        .req   (req),
        .lim0  (lim0),
        .lim1  (lim1),
        .gnt   (gnt),
        .o     (o),
        .done  (done),
        .busy  (busy)
    );

    always #5 pulse = ~pulse;

    typedef struct packed {
        logic [1:0]   gnt;
        logic [W-1:0] o;
        logic [1:0]   done;
        logic         busy;
    } exp_t;

    exp_t sb[$];

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Reference model state: 0 idle, 1 run, 2 done
    int           m_state;
    logic [1:0]   m_gnt;
    logic [W-1:0] m_o;
    logic [1:0]   m_done;
    logic         m_ptr;
    logic         m_own;
    logic [W-1:0] m_lim;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_gnt   = 2'b00;
        m_o     = '0;
        m_done  = 2'b00;
        m_ptr   = 1'b0;
        m_own   = 1'b0;
        m_lim   = '0;
    endtask

    task automatic model_step();
        exp_t e;
        if (reset) begin
            model_reset();
        end else begin
            case (m_state)
                0: begin
                    m_done = 2'b00;
                    if (req != 2'b00) begin
                        if (req == 2'b11) m_own = m_ptr;
                        else              m_own = (req == 2'b10);
                        m_gnt   = m_own ? 2'b10 : 2'b01;
                        m_o     = '0;
                        m_lim   = m_own ? lim1 : lim0;
                        m_state = 1;
                    end
                end
                1: begin
                    if (req[m_own] == 1'b0) begin
                        m_gnt   = 2'b00;
                        m_ptr   = !m_own;
                        m_state = 0;
                    end else if (m_o == m_lim) begin
                        m_gnt   = 2'b00;
                        m_done  = m_own ? 2'b10 : 2'b01;
                        m_state = 2;
                    end else begin
                        m_o = m_o + 1;
                    end
                end
                default: begin
                    m_done  = 2'b00;
                    m_ptr   = !m_own;
                    m_state = 0;
                end
            endcase
        end
        e.gnt  = m_gnt;
        e.o    = m_o;
        e.done = m_done;
        e.busy = (m_state != 0);
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge pulse);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("gnt",  gnt,  e.gnt);
            chk("o",    o,    e.o);
            chk("done", done, e.done);
            chk("busy", busy, e.busy);
            chk("gnt_onehot",  ($countones(gnt)  <= 1), 1);
            chk("done_onehot", ($countones(done) <= 1), 1);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 2'b00;
        lim0  = '0;
        lim1  = '0;
        model_reset();
        #1;
        chk("rst_gnt",  gnt,  2'b00);
        chk("rst_o",    o,    0);
        chk("rst_done", done, 2'b00);
        chk("rst_busy", busy, 1'b0);
        tick();
        reset = 1'b0;

        // Single request, limit 3
        req = 2'b01; lim0 = 3;
        tick();
        chk("t1_grant", gnt, 2'b01);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t1_count", o, i);
        end
        tick();
        chk("t1_done", done, 2'b01);
        chk("t1_gnt_off", gnt, 2'b00);
        req = 2'b00;
        tick();
        chk("t1_done_clr", done, 2'b00);
        chk("t1_idle", busy, 1'b0);

        // Limit 0 on requester 1
        req = 2'b10; lim1 = 0;
        tick();
        chk("t2_grant", gnt, 2'b10);
        tick();
        chk("t2_done", done, 2'b10);
        chk("t2_o", o, 0);
        req = 2'b00;
        tick();

        // Limit 15, no wrap
        req = 2'b01; lim0 = 15;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("t3_o_max", o, 15);
        tick();
        chk("t3_done", done, 2'b01);
        chk("t3_hold", o, 15);
        req = 2'b00;
        tick();
        chk("t3_nowrap", o, 15);

        // Abort while o = 2
        req = 2'b01; lim0 = 7;
        tick();
        tick();
        tick();
        chk("t4_o2", o, 2);
        req = 2'b00;
        tick();
        chk("t4_gnt", gnt, 2'b00);
        chk("t4_busy", busy, 1'b0);
        chk("t4_done", done, 2'b00);
        chk("t4_o", o, 2);
        tick();
        chk("t4_no_done", done, 2'b00);

        // Limit changed after grant
        req = 2'b01; lim0 = 2;
        tick();
        lim0 = 9;
        tick();
        tick();
        tick();
        chk("t5_done", done, 2'b01);
        chk("t5_o", o, 2);
        req = 2'b00;
        tick();

        // Mid-run asynchronous reset at o = 5
        req = 2'b01; lim0 = 9;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("t6_o5", o, 5);
        reset = 1'b1;
        #1;
        model_reset();
        chk("t6_o", o, 0);
        chk("t6_gnt", gnt, 2'b00);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 2'b00);
        tick();
        chk("t6_held", gnt, 2'b00);
        reset = 1'b0;
        tick();
        chk("t6_regrant", gnt, 2'b01);
        req = 2'b00;
        tick();

        // Contention from a fresh pointer
        reset = 1'b1;
        #1;
        model_reset();
        reset = 1'b0;
        req = 2'b11; lim0 = 1; lim1 = 2;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1)  chk("t7_first",  gnt,  2'b01);
            if (i == 3)  chk("t7_done0",  done, 2'b01);
            if (i == 5)  chk("t7_second", gnt,  2'b10);
            if (i == 7)  chk("t7_o2",     o,    2);
            if (i == 8)  chk("t7_done1",  done, 2'b10);
            if (i == 10) chk("t7_third",  gnt,  2'b01);
        end
        req = 2'b00;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cntr_arb.md
CNTR_ARB -- requirements
Module: cntr_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter, limit and output width in bits.
REQ-002 SHALL have port pulse, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req, input, 2 bits: req[i] high means requester i wants a counting run.
REQ-005 SHALL have port lim0, input, WIDTH bits: terminal count for requester 0.
REQ-006 SHALL have port lim1, input, WIDTH bits: terminal count for requester 1.
REQ-007 SHALL have port gnt, output, 2 bits: one-hot grant; 00 when no requester owns the counter.
REQ-008 SHALL have port o, output, WIDTH bits: shared counter value.
REQ-009 SHALL have port done, output, 2 bits: done[i] is a one-cycle pulse marking completion of requester i's run.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL implement exactly three states: IDLE, RUN, DONE.
REQ-012 SHALL, in IDLE with req != 00 at a rising edge, grant at that same edge (gnt one-hot, o <= 0, limit latched from lim0/lim1, state <= RUN).
REQ-013 SHALL arbitrate round-robin: with req = 11, grant the requester not served last; after reset the pointer favours requester 0.
REQ-014 SHALL, in RUN, increment o by 1 on each rising edge while o != latched limit and req[granted] = 1.
REQ-015 SHALL, in RUN with o == latched limit, at the next rising edge set state <= DONE, gnt <= 00, done[granted] <= 1, and hold o.
REQ-016 SHALL, in DONE, at the next rising edge clear done, toggle the pointer away from the served requester, and set state <= IDLE; no grant is issued from DONE.
REQ-017 SHALL treat limit 0 as valid: RUN lasts one cycle with o = 0, followed by DONE.
REQ-018 SHALL treat limit 2^WIDTH-1 as valid: o counts 0..15 (WIDTH=4) and never wraps.
REQ-019 SHALL ignore lim0/lim1 changes after the grant edge.
REQ-020 SHALL, if req[granted] falls during RUN, abort at the next edge: state <= IDLE, gnt <= 00, no done pulse, pointer moves away from the aborted requester, o held.
REQ-021 SHALL ignore a requester's req changes while the other requester owns the counter.
REQ-022 SHALL never assert more than one gnt bit or more than one done bit.
REQ-023 SHALL make a full run occupy L+2 cycles from the grant edge (L+1 in RUN, 1 in DONE), where L is the latched limit.

Reset
REQ-024 SHALL, on reset high, immediately and asynchronously force state = IDLE, gnt = 00, done = 00, o = 0, busy = 0, pointer = requester 0.
REQ-025 SHALL abandon any run in progress on a mid-run reset, with no done pulse.
REQ-026 SHALL grant no earlier than the first rising edge after reset falls.

Verification
REQ-027 SHALL cover a single request: req = 01, lim0 = 3 -> gnt = 01; o = 0,1,2,3 on successive edges; then done = 01 for one cycle, gnt = 00; then IDLE.
REQ-028 SHALL cover contention: req = 11 held, lim0 = 1, lim1 = 2 -> run for 0 (o 0..1), then run for 1 (o 0..2), then run for 0 again.
REQ-029 SHALL cover the limit boundaries: lim1 = 0 -> one RUN cycle with o = 0, then done = 10; lim0 = 15 -> o reaches 15, done = 01, no wrap.
REQ-030 SHALL cover abort: req drops 01 -> 00 while o = 2 -> next edge gnt = 00, busy = 0, done stays 00, o = 2.
REQ-031 SHALL cover a mid-run reset: reset pulsed while o = 5 -> o = 0, gnt = 00, busy = 0 without waiting for a clock edge.
REQ-032 SHALL cover a mid-run limit change: lim0 changes from 2 to 9 after the grant -> run still terminates at o = 2.
